// File: rtl/jt51_op_seq_if.sv
// Stage-I control bundle between the slot sequencer and the FM operator pipeline.
// The master side drives the clock enable and the channel config writes. The
// slave side (the sequencer) returns the per-slot controls.
interface jt51_op_seq_if;
  logic       cen;
  logic       wr_en;
  logic [2:0] wr_ch;
  logic [2:0] wr_con;
  logic [2:0] wr_fb;
  logic [2:0] cur_ch_I;
  logic [1:0] cur_op_I;
  logic [2:0] con_I;
  logic [2:0] fb_I;
  logic       m1_enters;
  logic       c1_enters;
  logic       use_prevprev1;
  logic       use_prev2;
  logic       use_internal_x;
  logic       use_prev1;
  logic       use_internal_y;
  logic       zero;

  modport master (
    output cen, wr_en, wr_ch, wr_con, wr_fb,
    input  cur_ch_I, cur_op_I, con_I, fb_I, m1_enters, c1_enters,
           use_prevprev1, use_prev2, use_internal_x, use_prev1, use_internal_y, zero
  );

  modport slave (
    input  cen, wr_en, wr_ch, wr_con, wr_fb,
    output cur_ch_I, cur_op_I, con_I, fb_I, m1_enters, c1_enters,
           use_prevprev1, use_prev2, use_internal_x, use_prev1, use_internal_y, zero
  );
endinterface

// File: rtl/jt51_op_seq.sv
// Slot sequencer and modulation router for the 32-slot FM operator pipeline.
// It walks 8 channels x 4 operators (M1, M2, C1, C2). It also holds the
// per-channel algorithm/feedback table and registers the stage-I controls for
// the slot that becomes current on each cen edge.
module jt51_op_seq (
  input  logic           clk,
  input  logic           rst_n,
  jt51_op_seq_if.slave   bus
);

  logic [4:0] slot;
  logic [4:0] slot_nx;
  logic [2:0] ch_nx;
  logic [1:0] op_nx;
  logic [5:0] cfg [8];   // {con, fb} per channel
  logic [5:0] cfg_nx;
  logic [4:0] sel_nx;    // {prevprev1, prev2, internal_x, prev1, internal_y}

  // Modulation-source routing by operator and algorithm. At most one x select
  // and one y select is ever set.
  function automatic logic [4:0] route(input logic [1:0] op, input logic [2:0] con);
    logic [4:0] s;
    s = 5'b00000;
    case (op)
      2'd0: s = 5'b10010;                      // M1 self-feedback
      2'd1: case (con)
              3'd0, 3'd2: s = 5'b01000;
              3'd1:       s = 5'b01010;
              3'd5:       s = 5'b00010;
              default:    s = 5'b00000;
            endcase
      2'd2: case (con)
              3'd0, 3'd3, 3'd4, 3'd5, 3'd6: s = 5'b00100;
              default:                      s = 5'b00000;
            endcase
      default: case (con)
              3'd0, 3'd1, 3'd4: s = 5'b00100;
              3'd2:             s = 5'b00110;
              3'd3:             s = 5'b01001;
              3'd5:             s = 5'b00010;
              default:          s = 5'b00000;
            endcase
    endcase
    return s;
  endfunction

  // Decode the slot about to be presented. The table read sees the pre-write
  // value, so a same-edge write only takes effect on the next visit.
  always_comb begin
    slot_nx = slot + 5'd1;
    ch_nx   = slot_nx[2:0];
    op_nx   = slot_nx[4:3];
    cfg_nx  = cfg[ch_nx];
    sel_nx  = route(op_nx, cfg_nx[5:3]);
  end

  // Slot counter and registered stage-I outputs, advanced together on cen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot               <= 5'd31;
      bus.cur_ch_I       <= 3'd0;
      bus.cur_op_I       <= 2'd0;
      bus.con_I          <= 3'd0;
      bus.fb_I           <= 3'd0;
      bus.m1_enters      <= 1'b0;
      bus.c1_enters      <= 1'b0;
      bus.use_prevprev1  <= 1'b0;
      bus.use_prev2      <= 1'b0;
      bus.use_internal_x <= 1'b0;
      bus.use_prev1      <= 1'b0;
      bus.use_internal_y <= 1'b0;
      bus.zero           <= 1'b0;
    end else if (bus.cen) begin
      slot               <= slot_nx;
      bus.cur_ch_I       <= ch_nx;
      bus.cur_op_I       <= op_nx;
      bus.con_I          <= cfg_nx[5:3];
      bus.fb_I           <= cfg_nx[2:0];
      bus.m1_enters      <= (op_nx == 2'd0);
      bus.c1_enters      <= (op_nx == 2'd2);
      bus.use_prevprev1  <= sel_nx[4];
      bus.use_prev2      <= sel_nx[3];
      bus.use_internal_x <= sel_nx[2];
      bus.use_prev1      <= sel_nx[1];
      bus.use_internal_y <= sel_nx[0];
      bus.zero           <= (slot_nx == 5'd0);
    end
  end

  // Channel config table, writable on any clock regardless of cen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) cfg[i] <= 6'd0;
    end else if (bus.wr_en) begin
      cfg[bus.wr_ch] <= {bus.wr_con, bus.wr_fb};
    end
  end

endmodule

// File: tb/tb_jt51_op_seq.sv
// Directed self-checking bench for the FM slot sequencer.
module tb_jt51_op_seq;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  jt51_op_seq_if bus ();

  jt51_op_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected selects {prevprev1, prev2, internal_x, prev1, internal_y}, from the routing table.
  function automatic logic [4:0] exp_sel(input logic [1:0] op, input logic [2:0] con);
    logic [4:0] e;
    e = 5'b00000;
    if (op == 2'd0) e = 5'b10010;
    else if (op == 2'd1) begin
      if (con == 3'd0 || con == 3'd2) e = 5'b01000;
      if (con == 3'd1)                e = 5'b01010;
      if (con == 3'd5)                e = 5'b00010;
    end else if (op == 2'd2) begin
      if (con == 3'd0 || con == 3'd3 || con == 3'd4 || con == 3'd5 || con == 3'd6) e = 5'b00100;
    end else begin
      if (con == 3'd0 || con == 3'd1 || con == 3'd4) e = 5'b00100;
      if (con == 3'd2) e = 5'b00110;
      if (con == 3'd3) e = 5'b01001;
      if (con == 3'd5) e = 5'b00010;
    end
    return e;
  endfunction

  function automatic logic [4:0] sel_now();
    return {bus.use_prevprev1, bus.use_prev2, bus.use_internal_x, bus.use_prev1, bus.use_internal_y};
  endfunction

  function automatic logic [18:0] all_out();
    return {bus.cur_ch_I, bus.cur_op_I, bus.con_I, bus.fb_I, bus.m1_enters, bus.c1_enters,
            sel_now(), bus.zero};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      bus.cen = 1'b1;
      @(negedge clk);
      bus.cen = 1'b0;
    end
  endtask

  task automatic wr_cfg(input logic [2:0] ch, input logic [2:0] con, input logic [2:0] fb);
    bus.wr_en = 1'b1; bus.wr_ch = ch; bus.wr_con = con; bus.wr_fb = fb;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (all_out() !== 19'd0) begin bad++; $display("FAIL reset_outputs got=%h want=0", all_out()); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (all_out() !== 19'd0) begin bad++; $display("FAIL reset_hold_no_cen got=%h want=0", all_out()); end
  endtask

  task automatic test_frame();
    logic [4:0] s;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      s = i[4:0];
      pulse(1);
      total++;
      if ({bus.cur_op_I, bus.cur_ch_I} !== s) begin
        bad++; $display("FAIL frame_slot i=%0d got=%0d want=%0d", i, {bus.cur_op_I, bus.cur_ch_I}, s);
      end
      total++;
      if (bus.zero !== (i == 0)) begin bad++; $display("FAIL frame_zero i=%0d got=%b", i, bus.zero); end
      total++;
      if ({bus.m1_enters, bus.c1_enters} !== {s[4:3] == 2'd0, s[4:3] == 2'd2}) begin
        bad++; $display("FAIL frame_enters i=%0d got=%b%b", i, bus.m1_enters, bus.c1_enters);
      end
    end
    pulse(1);
    total++;
    if (bus.zero !== 1'b1 || {bus.cur_op_I, bus.cur_ch_I} !== 5'd0) begin
      bad++; $display("FAIL frame_wrap got zero=%b slot=%0d want zero=1 slot=0", bus.zero, {bus.cur_op_I, bus.cur_ch_I});
    end
  endtask

  task automatic test_cen_gap();
    int es;
    logic [4:0] e5;
    do_reset();
    es = -1;
    for (int k = 0; k < 96; k++) begin
      bus.cen = (k % 3 == 0);
      @(negedge clk);
      if (bus.cen) es++;
      bus.cen = 1'b0;
      e5 = es[4:0];
      total++;
      if ({bus.cur_op_I, bus.cur_ch_I} !== e5) begin
        bad++; $display("FAIL cen_gap k=%0d got=%0d want=%0d", k, {bus.cur_op_I, bus.cur_ch_I}, e5);
      end
    end
    total++;
    if ({bus.cur_op_I, bus.cur_ch_I} !== 5'd31) begin
      bad++; $display("FAIL cen_gap_end got=%0d want=31", {bus.cur_op_I, bus.cur_ch_I});
    end
  endtask

  task automatic test_alg3();
    do_reset();
    wr_cfg(3'd3, 3'd3, 3'd5);
    pulse(28);
    total++;
    if ({bus.cur_op_I, bus.cur_ch_I} !== 5'd27) begin
      bad++; $display("FAIL alg3_slot got=%0d want=27", {bus.cur_op_I, bus.cur_ch_I});
    end
    total++;
    if (sel_now() !== 5'b01001) begin bad++; $display("FAIL alg3_sel got=%b want=01001", sel_now()); end
    total++;
    if (bus.fb_I !== 3'd5 || bus.con_I !== 3'd3) begin
      bad++; $display("FAIL alg3_cfg got con=%0d fb=%0d want con=3 fb=5", bus.con_I, bus.fb_I);
    end
  endtask

  task automatic test_sweep();
    logic [4:0] s;
    logic [2:0] c;
    for (int con = 0; con < 8; con++) begin
      do_reset();
      c = con[2:0];
      wr_cfg(3'd0, c, 3'd1);
      for (int i = 0; i < 32; i++) begin
        s = i[4:0];
        pulse(1);
        total++;
        if (sel_now() !== exp_sel(s[4:3], (s[2:0] == 3'd0) ? c : 3'd0)) begin
          bad++; $display("FAIL sweep con=%0d slot=%0d got=%b want=%b", con, i, sel_now(),
                          exp_sel(s[4:3], (s[2:0] == 3'd0) ? c : 3'd0));
        end
        total++;
        if ((bus.use_prevprev1 + bus.use_prev2 + bus.use_internal_x) > 1 ||
            (bus.use_prev1 + bus.use_internal_y) > 1) begin
          bad++; $display("FAIL sweep_exclusive con=%0d slot=%0d got=%b want=one_hot", con, i, sel_now());
        end
      end
    end
  endtask

  task automatic test_write_collision();
    do_reset();
    wr_cfg(3'd2, 3'd4, 3'd0);
    pulse(2);
    bus.cen = 1'b1;
    bus.wr_en = 1'b1; bus.wr_ch = 3'd2; bus.wr_con = 3'd7; bus.wr_fb = 3'd2;
    @(negedge clk);
    bus.cen = 1'b0; bus.wr_en = 1'b0;
    total++;
    if ({bus.cur_op_I, bus.cur_ch_I} !== 5'd2 || bus.con_I !== 3'd4) begin
      bad++; $display("FAIL collide_old slot=%0d got con=%0d want slot=2 con=4", {bus.cur_op_I, bus.cur_ch_I}, bus.con_I);
    end
    pulse(8);
    total++;
    if ({bus.cur_op_I, bus.cur_ch_I} !== 5'd10 || bus.con_I !== 3'd7 || bus.fb_I !== 3'd2) begin
      bad++; $display("FAIL collide_new slot=%0d got con=%0d fb=%0d want slot=10 con=7 fb=2",
                      {bus.cur_op_I, bus.cur_ch_I}, bus.con_I, bus.fb_I);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    wr_cfg(3'd5, 3'd5, 3'd6);
    pulse(18);
    total++;
    if ({bus.cur_op_I, bus.cur_ch_I} !== 5'd17) begin
      bad++; $display("FAIL midrst_pre got=%0d want=17", {bus.cur_op_I, bus.cur_ch_I});
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (all_out() !== 19'd0) begin bad++; $display("FAIL midrst_async got=%h want=0", all_out()); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulse(1);
    total++;
    if (bus.zero !== 1'b1 || {bus.cur_op_I, bus.cur_ch_I} !== 5'd0) begin
      bad++; $display("FAIL midrst_restart got zero=%b slot=%0d want zero=1 slot=0", bus.zero, {bus.cur_op_I, bus.cur_ch_I});
    end
    pulse(5);
    total++;
    if ({bus.cur_op_I, bus.cur_ch_I} !== 5'd5 || bus.con_I !== 3'd0 || bus.fb_I !== 3'd0) begin
      bad++; $display("FAIL midrst_table slot=%0d got con=%0d fb=%0d want slot=5 con=0 fb=0",
                      {bus.cur_op_I, bus.cur_ch_I}, bus.con_I, bus.fb_I);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.cen = 1'b0; bus.wr_en = 1'b0; bus.wr_ch = 3'd0; bus.wr_con = 3'd0; bus.wr_fb = 3'd0;
    test_reset();
    test_frame();
    test_cen_gap();
    test_alg3();
    test_sweep();
    test_write_collision();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
